approx_adder_pipe_monitor: RTL and testbench
============================================

// Module: approx_adder_pipe_monitor
// PURPOSE
//  Parametrised, pipelined approximate adder with a run-time error monitor.
//  The low APPROX_BITS of the sum use lower-part OR approximation; the upper bits are exact.
//  Each result carries its exact-vs-approximate error distance.
//  Saturating statistics count samples, threshold violations and the worst error, so error
//  budgets (ET) of synthesised approximate adders can be checked in-system.
// PARAMETERS
//  WIDTH        4   operand width (>=1); sum is WIDTH+1 bits
//  APPROX_BITS  2   number of LSBs approximated (0..WIDTH); 0 = exact adder
//  ET           2   error threshold; a result violates when err > ET
//  CNT_W        16  width of statistics counters
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  in_valid    in   1        operand beat valid
//  in_ready    out  1        block can accept a beat
//  in_a        in   WIDTH    operand A (unsigned)
//  in_b        in   WIDTH    operand B (unsigned)
//  approx_en   in   1        1 = approximate sum, 0 = exact sum; sampled with the beat
//  out_valid   out  1        result beat valid
//  out_ready   in   1        downstream accepts result
//  out_sum     out  WIDTH+1  selected sum (approximate or exact)
//  out_err     out  WIDTH+1  |exact - approximate| for this beat (0 when approx_en=0)
//  out_viol    out  1        out_err > ET
//  clr_stats   in   1        synchronous clear of statistics
//  sample_cnt  out  CNT_W    results transferred since reset/clear (saturating)
//  viol_cnt    out  CNT_W    transferred results with out_viol=1 (saturating)
//  max_err     out  WIDTH+1  largest out_err transferred since reset/clear
// BEHAVIOUR
//  Reset (async, rst_n=0): both pipe stages empty; all outputs 0 except in_ready=1.
//  Approximation, with K=APPROX_BITS:
//   - low[K-1:0] = a[K-1:0] | b[K-1:0]
//   - cin = a[K-1] & b[K-1] (0 if K=0)
//   - high = a[W-1:K] + b[W-1:K] + cin, WIDTH-K+1 bits
//   - approx = {high, low}
//   - K=WIDTH: approx = {a[K-1]&b[K-1], a|b}
//  exact = a + b, computed at WIDTH+1 bits with no truncation.
//  err = |exact - approx| (unsigned magnitude); out_viol = (err > ET).
//  Pipeline: S1 registers a, b, approx_en; S2 registers sum, err, viol.
//   - Each stage advances when empty or when the downstream stage frees.
//   - in_ready = !S1.valid | S1 advances (combinational).
//   - Latency: accepted beat appears on out_* 2 cycles later with out_ready=1.
//   - Throughput: 1 beat per cycle; no bubbles under continuous valid/ready.
//  Backpressure: while out_valid & !out_ready, out_sum, out_err and out_viol hold stable.
//   Pipe fills to 2 beats, then in_ready=0. No beat is dropped or duplicated.
//  Stats update on output transfer (out_valid & out_ready), one cycle after:
//   - sample_cnt += 1
//   - viol_cnt += out_viol
//   - max_err = max(max_err, out_err)
//   - Counters saturate at all-ones and do not wrap.
//  clr_stats=1: all stats become 0 next cycle. It has priority over a simultaneous transfer,
//   which is not counted. The data path is unaffected.
//  Reset mid-operation: in-flight beats are discarded and stats are zeroed.
// TESTING
//  1 W=4,K=2: a=3,b=3,approx_en=1 -> out_sum=7, out_err=1, out_viol=0, out_valid 2 cyc later.
//  2 a=2,b=3 approx -> sum=7, err=2, viol=0; same with approx_en=0 -> sum=5, err=0.
//  3 ET=1 override: a=2,b=2 approx -> sum=6, err=2, viol=1; viol_cnt=1, max_err=2.
//  4 out_ready=0 for 5 cyc while streaming 4 beats -> in_ready drops after 2 accepted, out_* stable;
//    release -> all 4 results in order, sample_cnt=4.
//  5 CNT_W=2: 5 transfers -> sample_cnt saturates at 3; clr_stats coincident with a transfer -> all stats 0.
//  6 K=0: random a,b -> err always 0, sum=a+b. rst_n pulsed mid-stream -> out_valid=0, stats=0, in_ready=1.

Source files
------------

// File: rtl/approx_adder_pipe_monitor.sv
`default_nettype none
// ============================================================================
// Module   : approx_adder_pipe_monitor
// Purpose  : Two-stage pipelined lower-part-OR approximate adder with a
//            run-time error monitor. Each result carries its
//            exact-vs-approximate error distance and a threshold-violation
//            flag. Saturating statistics accumulate on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module approx_adder_pipe_monitor #(
  parameter int WIDTH       = 4,
  parameter int APPROX_BITS = 2,
  parameter int ET          = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // operand side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             approx_en,
  // result side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_err,
  output logic             out_viol,
  // statistics
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [WIDTH:0]   max_err
);

  localparam int SW    = WIDTH + 1;
  localparam int K     = APPROX_BITS;
  // The threshold is compared at no less than 32 bits so that a threshold
  // wider than the error word never truncates.
  localparam int CMP_W = (SW > 32) ? SW : 32;
  localparam logic [CMP_W-1:0] C_ET = CMP_W'(ET);

  // Stage 1: raw operands and mode bit
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_en;

  // Stage 2: selected sum, error distance and violation flag
  logic             r_s2_valid;
  logic [SW-1:0]    r_s2_sum;
  logic [SW-1:0]    r_s2_err;
  logic             r_s2_viol;

  // Statistics
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_viol_cnt;
  logic [SW-1:0]    r_max_err;

  // Handshake / datapath wires
  logic             w_s2_free;
  logic             w_s1_free;
  logic             w_xfer;
  logic [SW-1:0]    w_exact;
  logic [SW-1:0]    w_approx;
  logic [SW-1:0]    w_diff;
  logic [SW-1:0]    w_sum;
  logic [SW-1:0]    w_err;
  logic             w_viol;

  // --------------------------------------------------------------------------
  // Handshake: a stage may load when it is empty or its content moves on in
  // the same cycle. in_ready is purely combinational so the pipe streams one
  // beat per cycle without bubbles.
  // --------------------------------------------------------------------------
  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s1_free = !r_s1_valid || w_s2_free;
  assign in_ready  = w_s1_free;
  assign w_xfer    = r_s2_valid && out_ready;

  // --------------------------------------------------------------------------
  // Exact reference sum, carried at full WIDTH+1 bits.
  // --------------------------------------------------------------------------
  assign w_exact = {1'b0, r_s1_a} + {1'b0, r_s1_b};

  // --------------------------------------------------------------------------
  // Approximate sum. The low K bits are the bitwise OR of the operands; the
  // AND of the top approximated bit pair feeds the exact upper adder as its
  // carry-in to recover most of the lost carry.
  // --------------------------------------------------------------------------
  generate
    if (K == 0) begin : g_exact_only
      assign w_approx = w_exact;
    end else if (K >= WIDTH) begin : g_all_approx
      assign w_approx = {r_s1_a[WIDTH-1] & r_s1_b[WIDTH-1], r_s1_a | r_s1_b};
    end else begin : g_lower_or
      logic [K-1:0]       w_low;
      logic               w_cin;
      logic [WIDTH-K:0]   w_high;
      assign w_low    = r_s1_a[K-1:0] | r_s1_b[K-1:0];
      assign w_cin    = r_s1_a[K-1] & r_s1_b[K-1];
      assign w_high   = {1'b0, r_s1_a[WIDTH-1:K]} + {1'b0, r_s1_b[WIDTH-1:K]}
                      + {{(WIDTH-K){1'b0}}, w_cin};
      assign w_approx = {w_high, w_low};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Mode selection and error distance. In exact mode the reported error is
  // zero because the exact sum is what leaves the block.
  // --------------------------------------------------------------------------
  assign w_diff = (w_exact >= w_approx) ? (w_exact - w_approx)
                                        : (w_approx - w_exact);
  assign w_sum  = r_s1_en ? w_approx : w_exact;
  assign w_err  = r_s1_en ? w_diff : '0;
  assign w_viol = CMP_W'(w_err) > C_ET;

  // Stage 1 register: capture an operand beat whenever the stage can load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_en    <= 1'b0;
    end else if (w_s1_free) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
        r_s1_en <= approx_en;
      end
    end
  end

  // Stage 2 register: results only change when the stage frees, so they hold
  // stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_err   <= '0;
      r_s2_viol  <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum  <= w_sum;
        r_s2_err  <= w_err;
        r_s2_viol <= w_viol;
      end
    end
  end

  // Statistics: clear wins over a simultaneous transfer; counters stick at
  // all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
      r_viol_cnt   <= '0;
      r_max_err    <= '0;
    end else if (clr_stats) begin
      r_sample_cnt <= '0;
      r_viol_cnt   <= '0;
      r_max_err    <= '0;
    end else if (w_xfer) begin
      if (r_sample_cnt != {CNT_W{1'b1}}) begin
        r_sample_cnt <= r_sample_cnt + 1'b1;
      end
      if (r_s2_viol && (r_viol_cnt != {CNT_W{1'b1}})) begin
        r_viol_cnt <= r_viol_cnt + 1'b1;
      end
      if (r_s2_err > r_max_err) begin
        r_max_err <= r_s2_err;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_sum    = r_s2_sum;
  assign out_err    = r_s2_err;
  assign out_viol   = r_s2_viol;
  assign sample_cnt = r_sample_cnt;
  assign viol_cnt   = r_viol_cnt;
  assign max_err    = r_max_err;

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_pipe_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_adder_pipe_monitor
// Purpose  : Self-checking bench for approx_adder_pipe_monitor. Three
//            instances share one stimulus stream:
//              0: W=4 K=2 ET=2 CNT_W=16
//              1: W=4 K=2 ET=1 CNT_W=2  (threshold override, saturation)
//              2: W=4 K=0 ET=2 CNT_W=16 (exact adder)
//            Expected results are queued at acceptance and compared when the
//            result appears; statistics are tracked by a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_adder_pipe_monitor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       approx_en;
  logic       out_ready;
  logic       clr_stats;

  logic        vld [3];
  logic        rdy [3];
  logic [4:0]  sum [3];
  logic [4:0]  err [3];
  logic        viol[3];
  logic [4:0]  mx  [3];
  logic [15:0] samp[3];
  logic [15:0] vcnt[3];
  logic [15:0] samp_a, vcnt_a, samp_c, vcnt_c;
  logic [1:0]  samp_b, vcnt_b;

  assign samp[0] = samp_a;
  assign vcnt[0] = vcnt_a;
  assign samp[1] = {14'd0, samp_b};
  assign vcnt[1] = {14'd0, vcnt_b};
  assign samp[2] = samp_c;
  assign vcnt[2] = vcnt_c;

  approx_adder_pipe_monitor #(.WIDTH(4), .APPROX_BITS(2), .ET(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .approx_en(approx_en),
    .out_valid(vld[0]), .out_ready(out_ready), .out_sum(sum[0]), .out_err(err[0]),
    .out_viol(viol[0]), .clr_stats(clr_stats), .sample_cnt(samp_a),
    .viol_cnt(vcnt_a), .max_err(mx[0]));

  approx_adder_pipe_monitor #(.WIDTH(4), .APPROX_BITS(2), .ET(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a), .in_b(in_b), .approx_en(approx_en),
    .out_valid(vld[1]), .out_ready(out_ready), .out_sum(sum[1]), .out_err(err[1]),
    .out_viol(viol[1]), .clr_stats(clr_stats), .sample_cnt(samp_b),
    .viol_cnt(vcnt_b), .max_err(mx[1]));

  approx_adder_pipe_monitor #(.WIDTH(4), .APPROX_BITS(0), .ET(2), .CNT_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_a(in_a), .in_b(in_b), .approx_en(approx_en),
    .out_valid(vld[2]), .out_ready(out_ready), .out_sum(sum[2]), .out_err(err[2]),
    .out_viol(viol[2]), .clr_stats(clr_stats), .sample_cnt(samp_c),
    .viol_cnt(vcnt_c), .max_err(mx[2]));

  always #5 clk = ~clk;

  // Per-instance configuration for the reference model
  int kk [3] = '{2, 2, 0};
  int et [3] = '{2, 1, 2};
  int cap[3] = '{65535, 3, 65535};

  typedef struct packed {
    logic [2:0][4:0] s;
    logic [2:0][4:0] e;
    logic [2:0]      v;
  } exp_t;

  exp_t sbq[$];
  int   m_samp[3];
  int   m_viol[3];
  int   m_max [3];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: timed out waiting on DUT", tag);
  endtask

  // Reference lower-part-OR adder written from the arithmetic definition
  function automatic int approx_sum(input int a, input int b, input int k);
    int low, cin, high;
    if (k == 0) return a + b;
    low  = (a | b) & ((1 << k) - 1);
    cin  = (a >> (k - 1)) & (b >> (k - 1)) & 1;
    high = (a >> k) + (b >> k) + cin;
    return (high << k) | low;
  endfunction

  function automatic exp_t make_exp(input int a, input int b, input bit en);
    exp_t x;
    int ex, ap, d;
    ex = a + b;
    for (int i = 0; i < 3; i++) begin
      ap = approx_sum(a, b, kk[i]);
      d  = en ? ((ex > ap) ? ex - ap : ap - ex) : 0;
      x.s[i] = 5'(en ? ap : ex);
      x.e[i] = 5'(d);
      x.v[i] = (d > et[i]);
    end
    return x;
  endfunction

  // Scoreboard / statistics monitor, sampling on the falling edge
  always @(negedge clk) begin
    exp_t hd;
    if (!rst_n) begin
      sbq.delete();
      for (int i = 0; i < 3; i++) begin
        m_samp[i] = 0; m_viol[i] = 0; m_max[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("sample_cnt[%0d]", i), 32'(samp[i]), m_samp[i]);
        chk($sformatf("viol_cnt[%0d]", i),   32'(vcnt[i]), m_viol[i]);
        chk($sformatf("max_err[%0d]", i),    32'(mx[i]),   m_max[i]);
        if (sbq.size() == 0) begin
          chk($sformatf("idle_out_valid[%0d]", i), 32'(vld[i]), 0);
        end else if (vld[i]) begin
          chk($sformatf("out_sum[%0d]", i),  32'(sum[i]),  32'(sbq[0].s[i]));
          chk($sformatf("out_err[%0d]", i),  32'(err[i]),  32'(sbq[0].e[i]));
          chk($sformatf("out_viol[%0d]", i), 32'(viol[i]), 32'(sbq[0].v[i]));
        end
      end
      if (vld[0] && out_ready && sbq.size() > 0) begin
        hd = sbq.pop_front();
        for (int i = 0; i < 3; i++) begin
          if (m_samp[i] < cap[i]) m_samp[i]++;
          if (hd.v[i] && m_viol[i] < cap[i]) m_viol[i]++;
          if (int'(hd.e[i]) > m_max[i]) m_max[i] = int'(hd.e[i]);
        end
      end
      if (clr_stats) begin
        for (int i = 0; i < 3; i++) begin
          m_samp[i] = 0; m_viol[i] = 0; m_max[i] = 0;
        end
      end
      if (in_valid && rdy[0]) sbq.push_back(make_exp(int'(in_a), int'(in_b), approx_en));
    end
  end

  // Present one beat and hold it until it is accepted
  task automatic send(input int a, input int b, input bit en);
    int t;
    in_a = 4'(a); in_b = 4'(b); approx_en = en; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rdy[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout_fail("send_accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait until every queued result has left the DUT
  task automatic drain();
    int t;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (sbq.size() != 0 && t < 100);
    if (sbq.size() != 0) timeout_fail("drain");
  endtask

  task automatic clear_pulse();
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_out_valid[%0d]", tag, i), 32'(vld[i]),  0);
      chk($sformatf("%s_in_ready[%0d]", tag, i),  32'(rdy[i]),  1);
      chk($sformatf("%s_out_sum[%0d]", tag, i),   32'(sum[i]),  0);
      chk($sformatf("%s_out_err[%0d]", tag, i),   32'(err[i]),  0);
      chk($sformatf("%s_out_viol[%0d]", tag, i),  32'(viol[i]), 0);
      chk($sformatf("%s_sample[%0d]", tag, i),    32'(samp[i]), 0);
      chk($sformatf("%s_violcnt[%0d]", tag, i),   32'(vcnt[i]), 0);
      chk($sformatf("%s_maxerr[%0d]", tag, i),    32'(mx[i]),   0);
    end
  endtask

  initial begin
    int t;
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    approx_en = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;

    // Reset state
    #12;
    check_idle_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3+3 approximate: sum 7, err 1, two cycles after presentation
    send(3, 3, 1);
    chk("lat_not_yet_valid", 32'(vld[0]), 0);
    @(posedge clk); #1;
    chk("t1_valid", 32'(vld[0]),  1);
    chk("t1_sum",   32'(sum[0]),  7);
    chk("t1_err",   32'(err[0]),  1);
    chk("t1_viol",  32'(viol[0]), 0);
    @(posedge clk); #1;

    // 2+3 approximate then exact
    send(2, 3, 1);
    @(posedge clk); #1;
    chk("t2_sum",    32'(sum[0]),  7);
    chk("t2_err",    32'(err[0]),  2);
    chk("t2_viol",   32'(viol[0]), 0);
    chk("t2_viol_b", 32'(viol[1]), 1);
    send(2, 3, 0);
    @(posedge clk); #1;
    chk("t2x_sum", 32'(sum[0]), 5);
    chk("t2x_err", 32'(err[0]), 0);
    @(posedge clk); #1;

    // Threshold override (instance 1, ET=1): 2+2 violates
    clear_pulse();
    send(2, 2, 1);
    @(posedge clk); #1;
    chk("t3_sum_b",  32'(sum[1]),  6);
    chk("t3_err_b",  32'(err[1]),  2);
    chk("t3_viol_b", 32'(viol[1]), 1);
    @(posedge clk); #1;
    chk("t3_violcnt_b", 32'(vcnt[1]), 1);
    chk("t3_maxerr_b",  32'(mx[1]),   2);

    // Backpressure: 4 beats against a stalled sink
    clear_pulse();
    out_ready = 1'b0;
    fork
      begin
        send(1, 2, 1);
        send(4, 5, 1);
        send(7, 9, 0);
        send(15, 15, 1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("t4_ready_drop", 32'(rdy[0]), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_ready_held", 32'(rdy[0]), 0);
        chk("t4_valid_held", 32'(vld[0]), 1);
        chk("t4_sum_held",   32'(sum[0]), 3);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_sample_cnt", 32'(samp[0]), 4);

    // Saturation on the 2-bit counters, then clear coincident with a transfer
    clear_pulse();
    for (int i = 0; i < 5; i++) send(i, 2 * i, 1);
    drain();
    chk("t5_sample_sat_b", 32'(samp[1]), 3);
    chk("t5_sample_a",     32'(samp[0]), 5);
    out_ready = 1'b0;
    send(3, 3, 1);
    t = 0;
    while (!vld[0] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!vld[0]) timeout_fail("t5_wait_valid");
    out_ready = 1'b1;
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_clr_sample[%0d]", i),  32'(samp[i]), 0);
      chk($sformatf("t5_clr_violcnt[%0d]", i), 32'(vcnt[i]), 0);
      chk($sformatf("t5_clr_maxerr[%0d]", i),  32'(mx[i]),   0);
    end

    // Random stream with random backpressure (exact instance must show err 0)
    fork
      begin
        repeat (30) send($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    chk("t6_sample_a", 32'(samp[0]), 30);

    // Reset in the middle of a full pipe
    out_ready = 1'b0;
    send(5, 6, 1);
    send(9, 3, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_reset("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(6, 7, 1);
    drain();
    chk("t6_post_reset_sample", 32'(samp[0]), 1);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
